minimips_mc_ctrl: RTL and testbench
===================================

# minimips_mc_ctrl

Multi-cycle control sequencer for the MiniMIPS datapath (16-bit instructions, 8×32-bit register file, 3-bit ALUctr). It replaces single-cycle combinational control: a state machine steps each instruction through fetch, decode, execute, memory and write-back. It drives all datapath enables and muxes, handles a variable-latency data-memory handshake, and halts at a programmed PC limit or on an illegal opcode.

## Interface
- HALT_PC, default 30: fetch address at or above which the core halts.
- CNT_W, default 16: width of the retired-instruction counter.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; IDLE→FETCH
- pc  in  32  current PC from the datapath (word index)
- opcode  in  4  IR[15:12]
- func  in  3  IR[2:0]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ack  in  1  data memory completion
- ir_load  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0: PC+1; 1: PC+sext(imm6)
- reg_write  out  1  register-file write enable
- reg_dst  out  1  0: rt; 1: rd
- alu_src  out  1  0: register; 1: immediate
- imm_zext  out  1  1: zero-extend imm6 (ANDI/ORI/NORI); 0: sign-extend
- alu_ctr  out  3  ALU operation
- mem_req  out  1  data memory request
- mem_we  out  1  store (valid with mem_req)
- mem_to_reg  out  1  write-back source is memory
- busy  out  1  state is not IDLE and not HALTED
- halted  out  1  sticky; set in HALTED
- illegal  out  1  sticky; set on undefined opcode/func
- retired  out  CNT_W  instructions completed

## Operation
- Encodings:
  - Opcodes: 0000 R-type, 0001 ADDI, 0010 ANDI, 0011 ORI, 0100 NORI, 0101 BEQ, 0110 BNE, 0111 SLTI, 1000 LW, 1001 SW.
  - Opcodes 1010–1111 are illegal.
- ALUctr / func: 000 AND, 001 ADD, 010 SUB, 011 XOR, 100 NOR, 101 OR, 110 SLT.
  - R-type with func 110 or 111 is illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
- IDLE:
  - All outputs 0.
  - start→FETCH.
- FETCH:
  - If pc ≥ HALT_PC → HALTED, with no ir_load.
  - Otherwise ir_load=1, pc_write=1, pc_src=0; → DECODE.
- DECODE:
  - Capture opcode and func into internal registers.
  - Illegal → HALTED and set illegal.
  - Otherwise → EXEC.
- EXEC:
  - alu_ctr and alu_src come from the captured opcode.
  - R-type and ADDI/ANDI/ORI/NORI/SLTI → WB.
  - LW/SW: alu_ctr=ADD, alu_src=1 → MEM.
  - BEQ/BNE: alu_ctr=SUB.
    - pc_write = zero (BEQ) or !zero (BNE), with pc_src=1.
    - retired += 1; → FETCH.
- MEM:
  - mem_req=1 and mem_we=(SW) are held every cycle until mem_ack=1 is sampled.
  - On ack: SW retires and → FETCH; LW → WB.
- WB:
  - reg_write=1.
  - reg_dst=1 only for R-type; mem_to_reg=1 only for LW.
  - retired += 1; → FETCH.
- HALTED:
  - Absorbing; only reset leaves it.
  - halted=1, and all enables are 0.
- retired wraps modulo 2^CNT_W.

## Timing
- Outputs are Moore-style, decoded from the state and the captured opcode/func.
  - They must not combinationally depend on opcode/func inputs outside DECODE.
- Reset values:
  - State IDLE; all outputs 0; retired=0; halted=0; illegal=0.
- Cycles per instruction:
  - ALU ops: 4 (F, D, E, W).
  - Branches: 3.
  - SW: 4 + wait cycles.
  - LW: 5 + wait cycles.
  - mem_ack in the first MEM cycle means zero wait cycles.
- Signals ignored when not in the stated state:
  - start is ignored unless in IDLE.
  - mem_ack is ignored outside MEM.
  - zero is used only in EXEC.
- Reset in any state, including MEM with a pending request: the next cycle is IDLE, mem_req=0, and counters are cleared.
- reset and start in the same cycle: reset wins.

## Structure
- Package minimips_pkg:
  - Opcode, func and ALUctr constants.
  - State enum.
  - HALT_PC default.
- Sub-module minimips_decode (combinational): captured opcode/func → {alu_ctr, alu_src, imm_zext, reg_dst, mem_to_reg, is_branch, is_mem, is_store, illegal}.
- The top level holds the FSM and counters only.

## Test plan
- Reset, start at pc=0, R-type ADD (func 001):
  - FETCH, DECODE, EXEC, WB in 4 cycles.
  - alu_ctr=001 in EXEC.
  - reg_write=1, reg_dst=1 in WB.
  - retired=1.
- LW with mem_ack delayed 3 cycles:
  - mem_req high for exactly 4 cycles with mem_we=0.
  - Then WB with mem_to_reg=1; 8 cycles total.
- BEQ with zero=1, then BNE with zero=1:
  - First: pc_write=1, pc_src=1 in EXEC.
  - Second: pc_write=0 in EXEC.
  - Each takes 3 cycles.
- Opcode 1100:
  - illegal=1 and halted=1 one cycle after DECODE.
  - No further ir_load; retired unchanged.
- Datapath pc=30 at FETCH:
  - → HALTED with retired equal to the prior count.
  - start pulses are ignored; reset returns to IDLE with all outputs 0.
- Reset asserted mid-MEM (SW waiting):
  - Next cycle mem_req=0, state IDLE, retired=0.
  - A late mem_ack is ignored.

Source files
------------

// File: rtl/minimips_pkg.sv
// Shared encodings, FSM state type and decoded-control bundle for the MiniMIPS
// multi-cycle controller.
package minimips_pkg;

  localparam int unsigned HALT_PC_DEF = 30;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_NORI  = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_BNE   = 4'h6;
  localparam logic [3:0] OP_SLTI  = 4'h7;
  localparam logic [3:0] OP_LW    = 4'h8;
  localparam logic [3:0] OP_SW    = 4'h9;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_e;

  typedef struct packed {
    logic [2:0] alu_ctr;
    logic       alu_src;
    logic       imm_zext;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       is_branch;
    logic       is_mem;
    logic       is_store;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/minimips_decode.sv
// Combinational instruction decode: opcode/func to ALU and datapath control
// fields, plus the illegal-instruction flag.
module minimips_decode
  import minimips_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [2:0] func_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        dec_o.alu_ctr = func_i;
        dec_o.reg_dst = 1'b1;
        // func 110/111 are reserved for R-type even though 110 is SLT on the ALU
        dec_o.illegal = (func_i[2:1] == 2'b11);
      end
      OP_ADDI: begin
        dec_o.alu_ctr = ALU_ADD;
        dec_o.alu_src = 1'b1;
      end
      OP_ANDI: begin
        dec_o.alu_ctr  = ALU_AND;
        dec_o.alu_src  = 1'b1;
        dec_o.imm_zext = 1'b1;
      end
      OP_ORI: begin
        dec_o.alu_ctr  = ALU_OR;
        dec_o.alu_src  = 1'b1;
        dec_o.imm_zext = 1'b1;
      end
      OP_NORI: begin
        dec_o.alu_ctr  = ALU_NOR;
        dec_o.alu_src  = 1'b1;
        dec_o.imm_zext = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.alu_ctr   = ALU_SUB;
        dec_o.is_branch = 1'b1;
      end
      OP_SLTI: begin
        dec_o.alu_ctr = ALU_SLT;
        dec_o.alu_src = 1'b1;
      end
      OP_LW: begin
        dec_o.alu_ctr    = ALU_ADD;
        dec_o.alu_src    = 1'b1;
        dec_o.is_mem     = 1'b1;
        dec_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_o.alu_ctr  = ALU_ADD;
        dec_o.alu_src  = 1'b1;
        dec_o.is_mem   = 1'b1;
        dec_o.is_store = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/minimips_mc_ctrl.sv
// Multi-cycle control sequencer for the MiniMIPS datapath.
//   state    | meaning
//   IDLE     | waiting for start, all outputs low
//   FETCH    | load IR, PC+1; halt instead if pc >= HALT_PC
//   DECODE   | capture opcode/func, trap illegal encodings
//   EXEC     | ALU op; branches resolve and retire here
//   MEM      | hold mem_req until mem_ack; SW retires here
//   WB       | register write-back, retire
//   HALTED   | absorbing until reset
module minimips_mc_ctrl
  import minimips_pkg::*;
#(
  parameter int unsigned HALT_PC = HALT_PC_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      pc_i,
  input  logic [3:0]       opcode_i,
  input  logic [2:0]       func_i,
  input  logic             zero_i,
  input  logic             mem_ack_i,
  output logic             ir_load_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             alu_src_o,
  output logic             imm_zext_o,
  output logic [2:0]       alu_ctr_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_to_reg_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e     state_q;
  logic [3:0] op_q;
  logic [2:0] fn_q;
  logic [3:0] op_sel;
  logic [2:0] fn_sel;
  dec_t       dec;
  logic       pc_ok;

  logic       fetch_q, branch_q, reg_write_q, reg_dst_q, alu_src_q, imm_zext_q;
  logic [2:0] alu_ctr_q;
  logic       mem_req_q, mem_we_q, mem_to_reg_q, halted_q, illegal_q;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Decode looks at the live IR only during DECODE; everywhere else it sees the
  // captured copy, so outputs never follow opcode/func outside that state.
  assign op_sel = (state_q == S_DECODE) ? opcode_i : op_q;
  assign fn_sel = (state_q == S_DECODE) ? func_i   : fn_q;

  minimips_decode u_decode (
    .opcode_i (op_sel),
    .func_i   (fn_sel),
    .dec_o    (dec)
  );

  assign pc_ok     = (pc_i < HALT_PC);
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      fn_q         <= '0;
      fetch_q      <= 1'b0;
      branch_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      imm_zext_q   <= 1'b0;
      alu_ctr_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      // Registered outputs describe the state being entered; default them low.
      fetch_q      <= 1'b0;
      branch_q     <= 1'b0;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      imm_zext_q   <= 1'b0;
      alu_ctr_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            fetch_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!pc_ok) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          op_q <= opcode_i;
          fn_q <= func_i;
          if (dec.illegal) begin
            state_q   <= S_HALTED;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else begin
            state_q    <= S_EXEC;
            alu_ctr_q  <= dec.alu_ctr;
            alu_src_q  <= dec.alu_src;
            imm_zext_q <= dec.imm_zext;
            branch_q   <= dec.is_branch;
          end
        end
        S_EXEC: begin
          if (dec.is_branch) begin
            state_q   <= S_FETCH;
            fetch_q   <= 1'b1;
            retired_q <= retired_d;
          end else if (dec.is_mem) begin
            state_q   <= S_MEM;
            mem_req_q <= 1'b1;
            mem_we_q  <= dec.is_store;
          end else begin
            state_q     <= S_WB;
            reg_write_q <= 1'b1;
            reg_dst_q   <= dec.reg_dst;
          end
        end
        S_MEM: begin
          if (!mem_ack_i) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= dec.is_store;
          end else if (dec.is_store) begin
            state_q   <= S_FETCH;
            fetch_q   <= 1'b1;
            retired_q <= retired_d;
          end else begin
            state_q      <= S_WB;
            reg_write_q  <= 1'b1;
            mem_to_reg_q <= dec.mem_to_reg;
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          fetch_q   <= 1'b1;
          retired_q <= retired_d;
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Fetch enables gate on the live PC, branch write on the live zero flag:
  // both may change on the very edge that enters the state.
  assign ir_load_o    = fetch_q & pc_ok;
  assign pc_write_o   = (fetch_q & pc_ok) | (branch_q & (zero_i ^ (op_q == OP_BNE)));
  assign pc_src_o     = branch_q;
  assign reg_write_o  = reg_write_q;
  assign reg_dst_o    = reg_dst_q;
  assign alu_src_o    = alu_src_q;
  assign imm_zext_o   = imm_zext_q;
  assign alu_ctr_o    = alu_ctr_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted_o     = halted_q;
  assign illegal_o    = illegal_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_minimips_mc_ctrl.sv
// Directed plus randomized bench for minimips_mc_ctrl; expected per-cycle
// outputs come from an instruction-level model of the sequencing rules.
module tb_minimips_mc_ctrl;

  logic        clk;
  logic        reset_i, start_i, zero_i, mem_ack_i;
  logic [31:0] pc_i;
  logic [3:0]  opcode_i;
  logic [2:0]  func_i;
  logic        ir_load_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o, alu_src_o, imm_zext_o;
  logic [2:0]  alu_ctr_o;
  logic        mem_req_o, mem_we_o, mem_to_reg_o, busy_o, halted_o, illegal_o;
  logic [15:0] retired_o;

  typedef struct packed {
    logic        ir_load, pc_write, pc_src, reg_write, reg_dst, alu_src, imm_zext;
    logic [2:0]  alu_ctr;
    logic        mem_req, mem_we, mem_to_reg, busy, halted, illegal;
    logic [15:0] retired;
  } obs_t;

  obs_t obs;
  int   checks = 0;
  int   errors = 0;

  int unsigned pc_m;
  logic [15:0] ret_m;
  logic        halted_m, illegal_m;

  minimips_mc_ctrl dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .pc_i(pc_i),
    .opcode_i(opcode_i), .func_i(func_i), .zero_i(zero_i), .mem_ack_i(mem_ack_i),
    .ir_load_o(ir_load_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .alu_src_o(alu_src_o),
    .imm_zext_o(imm_zext_o), .alu_ctr_o(alu_ctr_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_to_reg_o(mem_to_reg_o), .busy_o(busy_o),
    .halted_o(halted_o), .illegal_o(illegal_o), .retired_o(retired_o)
  );

  assign obs = {ir_load_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o, alu_src_o,
                imm_zext_o, alu_ctr_o, mem_req_o, mem_we_o, mem_to_reg_o, busy_o,
                halted_o, illegal_o, retired_o};

  always #5 clk = ~clk;

  function automatic obs_t idle_obs();
    obs_t e = '0;
    e.retired = ret_m;
    return e;
  endfunction

  function automatic obs_t busy_obs();
    obs_t e = '0;
    e.busy    = 1'b1;
    e.retired = ret_m;
    return e;
  endfunction

  function automatic obs_t halt_obs();
    obs_t e = '0;
    e.halted  = 1'b1;
    e.illegal = illegal_m;
    e.retired = ret_m;
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op, input logic [2:0] fn);
    case (op)
      4'd0:             return fn;
      4'd2:             return 3'b000;
      4'd3:             return 3'b101;
      4'd4:             return 3'b100;
      4'd5, 4'd6:       return 3'b010;
      4'd7:             return 3'b110;
      default:          return 3'b001;
    endcase
  endfunction

  task automatic step(input string tag, input obs_t e);
    @(negedge clk);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    opcode_i  = 4'($urandom);
    func_i    = 3'($urandom);
    zero_i    = 1'($urandom);
    mem_ack_i = 1'($urandom);
    start_i   = 1'($urandom);
    pc_i      = pc_m;
  endtask

  task automatic do_reset(input logic with_start);
    reset_i = 1'b1;
    start_i = with_start;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    start_i = 1'b0;
    mem_ack_i = 1'b1;
    ret_m = '0; halted_m = 1'b0; illegal_m = 1'b0; pc_m = 0;
    pc_i = pc_m;
    step("after_reset", idle_obs());
    mem_ack_i = 1'b0;
  endtask

  task automatic do_start();
    noise();
    start_i = 1'b1;
    step("idle_start", idle_obs());
  endtask

  // Steps one instruction from FETCH; rst_k >= 0 asserts reset in that MEM wait cycle.
  task automatic do_instr(input logic [3:0] op, input logic [2:0] fn, input logic z,
                          input int waits, input int rst_k);
    obs_t e;
    logic ill, br, mem, st, taken;
    ill = (op >= 4'd10) || (op == 4'd0 && fn >= 3'd6);
    br  = (op == 4'd5) || (op == 4'd6);
    mem = (op == 4'd8) || (op == 4'd9);
    st  = (op == 4'd9);
    noise();
    e = busy_obs();
    if (pc_m >= 30) begin
      step("fetch_at_limit", e);
      halted_m = 1'b1;
      noise();
      step("halt_at_limit", halt_obs());
      return;
    end
    e.ir_load = 1'b1; e.pc_write = 1'b1;
    step("fetch", e);
    pc_m++;
    noise();
    opcode_i = op; func_i = fn;
    step("decode", busy_obs());
    if (ill) begin
      illegal_m = 1'b1; halted_m = 1'b1;
      noise();
      step("illegal_halt", halt_obs());
      return;
    end
    noise();
    zero_i = z;
    e = busy_obs();
    e.alu_ctr  = alu_of(op, fn);
    e.alu_src  = (op != 4'd0) && !br;
    e.imm_zext = (op inside {4'd2, 4'd3, 4'd4});
    if (br) begin
      taken = (op == 4'd5) ? z : !z;
      e.pc_src = 1'b1; e.pc_write = taken;
      step("exec_branch", e);
      if (taken) pc_m = $urandom_range(0, 25);
      ret_m++;
      return;
    end
    step("exec", e);
    if (mem) begin
      for (int k = 0; k <= waits; k++) begin
        noise();
        mem_ack_i = (k == waits);
        e = busy_obs(); e.mem_req = 1'b1; e.mem_we = st;
        if (k == rst_k) begin
          mem_ack_i = 1'b0;
          reset_i = 1'b1;
          step("mem_before_reset", e);
          reset_i = 1'b0; start_i = 1'b0; mem_ack_i = 1'b1;
          ret_m = '0; halted_m = 1'b0; illegal_m = 1'b0; pc_m = 0; pc_i = pc_m;
          step("reset_mid_mem", idle_obs());
          step("late_ack_ignored", idle_obs());
          mem_ack_i = 1'b0;
          return;
        end
        step("mem", e);
      end
      if (st) begin
        ret_m++;
        return;
      end
    end
    noise();
    e = busy_obs(); e.reg_write = 1'b1; e.reg_dst = (op == 4'd0); e.mem_to_reg = (op == 4'd8);
    step("wb", e);
    ret_m++;
  endtask

  task automatic halted_idle(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      start_i = i[0];
      step("halted_sticky", halt_obs());
    end
  endtask

  initial begin
    logic [3:0] op;
    logic [2:0] fn;
    clk = 1'b0; reset_i = 1'b1; start_i = 1'b0; pc_i = '0; opcode_i = '0;
    func_i = '0; zero_i = 1'b0; mem_ack_i = 1'b0;
    pc_m = 0; ret_m = '0; halted_m = 1'b0; illegal_m = 1'b0;
    #1;
    do_reset(1'b1);
    do_start();
    do_instr(4'd0, 3'b001, 1'b0, 0, -1);
    do_instr(4'd8, 3'b000, 1'b0, 3, -1);
    do_instr(4'd5, 3'b000, 1'b1, 0, -1);
    do_instr(4'd6, 3'b000, 1'b1, 0, -1);
    do_instr(4'd2, 3'b000, 1'b0, 0, -1);
    do_instr(4'd3, 3'b000, 1'b0, 0, -1);
    do_instr(4'd4, 3'b000, 1'b0, 0, -1);
    do_instr(4'd7, 3'b000, 1'b0, 0, -1);
    do_instr(4'd9, 3'b000, 1'b0, 0, -1);
    do_instr(4'd1, 3'b000, 1'b0, 0, -1);
    do_instr(4'd12, 3'b000, 1'b0, 0, -1);
    halted_idle(3);

    do_reset(1'b0);
    do_start();
    do_instr(4'd0, 3'b101, 1'b0, 0, -1);
    pc_m = 30;
    do_instr(4'd0, 3'b001, 1'b0, 0, -1);
    halted_idle(4);
    do_reset(1'b0);

    do_start();
    do_instr(4'd0, 3'b010, 1'b0, 0, -1);
    do_instr(4'd9, 3'b000, 1'b0, 5, 2);

    do_start();
    do_instr(4'd0, 3'b111, 1'b0, 0, -1);
    halted_idle(2);

    do_reset(1'b0);
    do_start();
    for (int i = 0; i < 120; i++) begin
      if (halted_m) begin
        do_reset(1'($urandom));
        do_start();
      end
      op = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 24) == 0) op = 4'($urandom_range(10, 15));
      fn = (op == 4'd0) ? 3'($urandom_range(0, 5)) : 3'($urandom);
      if (op == 4'd0 && $urandom_range(0, 29) == 0) fn = 3'($urandom_range(6, 7));
      do_instr(op, fn, 1'($urandom), int'($urandom_range(0, 4)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
